// File: rtl/atri_frame_builder.sv
// atri_frame_builder
//   Framing stage for the 16-bit event word path. For each event it emits a
//   header {HDR_TAG, seq}, the payload words (at most MAX_WORDS; any beyond
//   that are consumed and dropped), a length word {trunc, count[14:0]} and a
//   checksum word. The checksum is the 16-bit wrapping sum of every word
//   loaded before it and is flagged with last.
//
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   dat_i/valid_i/last_i/ready_o   upstream raw words (valid/ready)
//   dat_o/valid_o/last_o/ready_i   downstream framed words (registered)
//   seq_o             sequence number the next frame will carry
//   trunc_o           one-cycle pulse when a frame closes truncated
module atri_frame_builder #(
    parameter logic [7:0]  HDR_TAG   = 8'hA5,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] dat_i,
    input  logic        valid_i,
    input  logic        last_i,
    output logic        ready_o,
    output logic [15:0] dat_o,
    output logic        valid_o,
    output logic        last_o,
    input  logic        ready_i,
    output logic [7:0]  seq_o,
    output logic        trunc_o
);

    localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

    typedef enum logic [1:0] {IDLE, PAYLOAD, LEN, CSUM} state_t;

    state_t      state, state_nx;
    logic [15:0] count, sum;
    logic        trunc_flag;
    logic        slot_free, in_xfer;
    logic        load, load_last;
    logic [15:0] load_dat;
    logic        hdr_load, pay_keep, pay_drop, csum_load;

    // Single output register: it can take a new word when empty or when the
    // current word leaves this cycle.
    assign slot_free = !valid_o || ready_i;

    always_comb begin
        state_nx  = state;
        ready_o   = 1'b0;
        in_xfer   = 1'b0;
        load      = 1'b0;
        load_dat  = '0;
        load_last = 1'b0;
        hdr_load  = 1'b0;
        pay_keep  = 1'b0;
        pay_drop  = 1'b0;
        csum_load = 1'b0;
        case (state)
            IDLE: begin
                // The header goes out ahead of the first word; that word
                // stays pending upstream until PAYLOAD.
                if (valid_i && slot_free) begin
                    hdr_load = 1'b1;
                    load     = 1'b1;
                    load_dat = {HDR_TAG, seq_o};
                    state_nx = PAYLOAD;
                end
            end
            PAYLOAD: begin
                ready_o = slot_free;
                in_xfer = valid_i && slot_free;
                if (in_xfer) begin
                    if (count < MAX_CNT) begin
                        pay_keep = 1'b1;
                        load     = 1'b1;
                        load_dat = dat_i;
                    end else begin
                        // Over the limit: still consume, just drop it.
                        pay_drop = 1'b1;
                    end
                    if (last_i) state_nx = LEN;
                end
            end
            LEN: begin
                if (slot_free) begin
                    load     = 1'b1;
                    load_dat = {trunc_flag, count[14:0]};
                    state_nx = CSUM;
                end
            end
            CSUM: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_dat  = sum;
                    load_last = 1'b1;
                    csum_load = 1'b1;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            dat_o      <= '0;
            valid_o    <= 1'b0;
            last_o     <= 1'b0;
            seq_o      <= '0;
            trunc_o    <= 1'b0;
            count      <= '0;
            sum        <= '0;
            trunc_flag <= 1'b0;
        end else begin
            state   <= state_nx;
            trunc_o <= 1'b0;

            if (load) begin
                dat_o   <= load_dat;
                valid_o <= 1'b1;
                last_o  <= load_last;
            end else if (ready_i) begin
                valid_o <= 1'b0;
                last_o  <= 1'b0;
            end

            if (hdr_load) begin
                sum   <= load_dat;
                count <= '0;
            end else if (csum_load) begin
                // Checksum word itself is not summed; frame state clears.
                sum        <= '0;
                count      <= '0;
                trunc_flag <= 1'b0;
                trunc_o    <= trunc_flag;
                seq_o      <= seq_o + 8'd1;
            end else if (load) begin
                sum <= sum + load_dat;
            end

            if (pay_keep) count      <= count + 16'd1;
            if (pay_drop) trunc_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_atri_frame_builder.sv
module tb_atri_frame_builder;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] dat_i = '0;
  logic        valid_i = 1'b0;
  logic        last_i = 1'b0;
  logic        ready_i = 1'b1;

  logic [15:0] a_dat, b_dat;
  logic        a_vld, b_vld, a_lst, b_lst, a_rdy, b_rdy, a_trc, b_trc;
  logic [7:0]  a_seq, b_seq;

  always #5 clk = ~clk;

  atri_frame_builder u_dut (
    .clk_i(clk), .rst_i(rst_i), .dat_i(dat_i), .valid_i(valid_i),
    .last_i(last_i), .ready_o(a_rdy), .dat_o(a_dat), .valid_o(a_vld),
    .last_o(a_lst), .ready_i(ready_i), .seq_o(a_seq), .trunc_o(a_trc)
  );

  atri_frame_builder #(.MAX_WORDS(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst_i), .dat_i(dat_i), .valid_i(valid_i),
    .last_i(last_i), .ready_o(b_rdy), .dat_o(b_dat), .valid_o(b_vld),
    .last_o(b_lst), .ready_i(ready_i), .seq_o(b_seq), .trunc_o(b_trc)
  );

  // sel picks which instance the driver and monitor follow.
  logic        sel = 1'b0;
  logic        tog = 1'b0;
  logic        stab_en = 1'b0;
  logic [15:0] m_dat;
  logic        m_vld, m_lst, m_rdy, m_trc;
  assign m_dat = sel ? b_dat : a_dat;
  assign m_vld = sel ? b_vld : a_vld;
  assign m_lst = sel ? b_lst : a_lst;
  assign m_rdy = sel ? b_rdy : a_rdy;
  assign m_trc = sel ? b_trc : a_trc;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int trc_cnt = 0;
  int first_cyc = -1;
  int last_cyc = -1;
  logic [16:0] outq[$];
  logic [16:0] expq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ready_i: held high, or toggled each cycle when tog is set.
  initial begin
    forever begin
      @(posedge clk); #1;
      ready_i = tog ? ~ready_i : 1'b1;
    end
  end

  // Monitor: sampled on the falling edge, so a transfer seen here happens
  // at the following rising edge.
  logic        p_vld = 1'b0, p_rdy = 1'b0;
  logic [15:0] p_dat = '0;
  always @(negedge clk) begin
    cyc++;
    if (!rst_i) begin
      if (m_trc) trc_cnt++;
      if (m_vld && ready_i) begin
        outq.push_back({m_lst, m_dat});
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
      if (stab_en && p_vld && !p_rdy) begin
        chk("hold_dat", m_dat, p_dat);
        chk("hold_vld", m_vld, 1);
      end
      if (stab_en && m_vld && !ready_i) chk("rdy_blocked", m_rdy, 0);
    end
    p_vld = m_vld && !rst_i;
    p_rdy = ready_i;
    p_dat = m_dat;
  end

  task automatic do_reset();
    valid_i = 1'b0; last_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    outq.delete(); expq.delete();
    trc_cnt = 0; first_cyc = -1; last_cyc = -1;
  endtask

  // Present one word and hold it until it is accepted; valid_i stays high
  // afterwards so consecutive calls run back-to-back.
  task automatic send(input logic [15:0] w, input logic l);
    bit done = 0;
    dat_i = w; last_i = l; valid_i = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (m_rdy) begin
        @(posedge clk); #1;
        done = 1;
      end
    end
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic idle_in();
    valid_i = 1'b0; last_i = 1'b0;
  endtask

  task automatic push_exp(input logic [15:0] w, input logic l);
    expq.push_back({l, w});
  endtask

  // Wait (bounded) for the expected number of output words, then compare.
  task automatic check_stream(input string tag);
    for (int i = 0; i < 5000 && outq.size() < expq.size(); i++) @(negedge clk);
    repeat (6) @(negedge clk);
    chk({tag, "_len"}, outq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < outq.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), outq[i], expq[i]);
  endtask

  initial begin
    repeat (3) @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    // Reset state (rst_i released; nothing presented yet)
    chk("rst_vld", a_vld, 0);
    chk("rst_lst", a_lst, 0);
    chk("rst_dat", a_dat, 0);
    chk("rst_rdy", a_rdy, 0);
    chk("rst_seq", a_seq, 0);
    chk("rst_trc", a_trc, 0);
    @(posedge clk); #1;
    do_reset();

    // Basic three-word frame
    send(16'h0001, 0); send(16'h0002, 0); send(16'h0003, 1); idle_in();
    push_exp(16'hA500, 0); push_exp(16'h0001, 0); push_exp(16'h0002, 0);
    push_exp(16'h0003, 0); push_exp(16'h0003, 0); push_exp(16'hA509, 1);
    check_stream("basic");
    chk("basic_seq", a_seq, 1);
    chk("basic_trc", trc_cnt, 0);

    // Same event under toggling backpressure; seq is now 1
    outq.delete(); expq.delete();
    tog = 1'b1; stab_en = 1'b1;
    send(16'h0001, 0); send(16'h0002, 0); send(16'h0003, 1); idle_in();
    push_exp(16'hA501, 0); push_exp(16'h0001, 0); push_exp(16'h0002, 0);
    push_exp(16'h0003, 0); push_exp(16'h0003, 0); push_exp(16'hA50A, 1);
    check_stream("bp");
    chk("bp_seq", a_seq, 2);
    tog = 1'b0; stab_en = 1'b0;
    @(posedge clk); #1;

    // Truncation on the MAX_WORDS=4 instance
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) send(16'h1111, i == 5);
    idle_in();
    push_exp(16'hA500, 0);
    for (int i = 0; i < 4; i++) push_exp(16'h1111, 0);
    push_exp(16'h8004, 0); push_exp(16'h6948, 1);
    check_stream("trunc");
    chk("trunc_pulses", trc_cnt, 1);
    chk("trunc_seq", b_seq, 1);
    sel = 1'b0;

    // Single word, checksum wraps
    do_reset();
    send(16'hFFFF, 1); idle_in();
    push_exp(16'hA500, 0); push_exp(16'hFFFF, 0);
    push_exp(16'h0001, 0); push_exp(16'hA500, 1);
    check_stream("wrap");

    // 257 back-to-back one-word frames: seq wraps, 4 cycles per frame
    do_reset();
    for (int k = 0; k < 257; k++) begin
      logic [7:0] s;
      s = 8'(k);
      send(16'(k), 1);
      push_exp({8'hA5, s}, 0); push_exp(16'(k), 0); push_exp(16'h0001, 0);
      push_exp(16'hA500 + {8'h00, s} + 16'(k) + 16'h0001, 1);
    end
    idle_in();
    check_stream("b2b");
    chk("b2b_span", last_cyc - first_cyc, 257 * 4 - 1);
    chk("b2b_seq", a_seq, 1);

    // Reset mid-frame after two payload words
    do_reset();
    send(16'h00AA, 0); send(16'h00BB, 0); idle_in();
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("mid_vld", a_vld, 0);
    chk("mid_seq", a_seq, 0);
    outq.delete(); expq.delete();
    repeat (10) @(negedge clk);
    chk("mid_stale", outq.size(), 0);
    @(posedge clk); #1;
    send(16'h0005, 1); idle_in();
    push_exp(16'hA500, 0); push_exp(16'h0005, 0);
    push_exp(16'h0001, 0); push_exp(16'hA506, 1);
    check_stream("mid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
